// File: rtl/conv_mac_pkg.sv
// Shared types, default widths and requantisation helpers for the conv MAC pipeline.
package conv_mac_pkg;

    localparam int DEF_A_W       = 16;
    localparam int DEF_B_W       = 8;
    localparam int DEF_NUM_STAGE = 2;
    localparam int DEF_ACC_W     = 32;
    localparam int DEF_SHIFT     = 8;
    localparam int DEF_OUT_W     = 16;

    // Working width for requantisation. It is wide enough that the rounding
    // bias can never overflow an accumulator narrower than this.
    localparam int CALC_W = 64;

    // Sideband carried alongside each product through the multiplier stages.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } mac_tag_t;

    typedef struct packed {
        logic                     sat;
        logic signed [CALC_W-1:0] value;
    } sat_res_t;

    // Add half an LSB of the result, then arithmetic shift.
    // The net effect is round half toward +inf.
    function automatic logic signed [CALC_W-1:0] round_shift(
        input logic signed [CALC_W-1:0] value,
        input int                       shift
    );
        logic signed [CALC_W-1:0] bias;
        bias = '0;
        if (shift > 0) begin
            bias = 64'sd1 <<< (shift - 1);
        end
        return (value + bias) >>> shift;
    endfunction

    // Clamp to the signed out_w-bit range and flag whether clamping happened.
    function automatic sat_res_t saturate(
        input logic signed [CALC_W-1:0] value,
        input int                       out_w
    );
        logic signed [CALC_W-1:0] max_v;
        logic signed [CALC_W-1:0] min_v;
        sat_res_t                 res;
        max_v     = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v     = -(64'sd1 <<< (out_w - 1));
        res.sat   = 1'b0;
        res.value = value;
        if (value > max_v) begin
            res.value = max_v;
            res.sat   = 1'b1;
        end else if (value < min_v) begin
            res.value = min_v;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/conv_mac_pipe_if.sv
// Beat/result stream bundle between line buffers, the MAC, and the output stream.
interface conv_mac_pipe_if
    import conv_mac_pkg::*;
#(
    parameter int A_W   = DEF_A_W,
    parameter int B_W   = DEF_B_W,
    parameter int OUT_W = DEF_OUT_W
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [A_W-1:0]   din0;
    logic signed [B_W-1:0]   din1;
    logic                    in_first;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] dout;
    logic                    out_sat;

    // Producer of beats and consumer of results.
    modport master (
        output in_valid, din0, din1, in_first, in_last, out_ready,
        input  in_ready, out_valid, dout, out_sat
    );

    // The MAC itself.
    modport slave (
        input  in_valid, din0, din1, in_first, in_last, out_ready,
        output in_ready, out_valid, dout, out_sat
    );
endinterface

// File: rtl/conv_mac_mul_pipe.sv
// Full-precision signed multiply followed by NUM_STAGE enable-gated registers.
// The window tags travel with each product through the stages.
module conv_mac_mul_pipe
    import conv_mac_pkg::*;
#(
    parameter int A_W       = DEF_A_W,
    parameter int B_W       = DEF_B_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int NUM_STAGE = DEF_NUM_STAGE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic signed [A_W-1:0]   i_a,
    input  logic signed [B_W-1:0]   i_b,
    input  mac_tag_t                i_tag,
    output logic signed [ACC_W-1:0] o_prod,
    output mac_tag_t                o_tag
);
    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]   w_prod_full;
    logic signed [ACC_W-1:0] w_prod_ext;

    // Both operands are widened before the multiply, so the product is exact.
    assign w_prod_full = P_W'(i_a) * P_W'(i_b);
    assign w_prod_ext  = ACC_W'(w_prod_full);

    for (genvar gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
        logic signed [ACC_W-1:0] r_prod;
        mac_tag_t                r_tag;

        if (gi == 0) begin : g_head
            // Capture the fresh product and its tag when the pipeline advances.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_prod <= '0;
                    r_tag  <= '0;
                end else if (en) begin
                    r_prod <= w_prod_ext;
                    r_tag  <= i_tag;
                end
            end
        end else begin : g_body
            // Shift the previous stage forward when the pipeline advances.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_prod <= '0;
                    r_tag  <= '0;
                end else if (en) begin
                    r_prod <= g_stage[gi-1].r_prod;
                    r_tag  <= g_stage[gi-1].r_tag;
                end
            end
        end
    end

    assign o_prod = g_stage[NUM_STAGE-1].r_prod;
    assign o_tag  = g_stage[NUM_STAGE-1].r_tag;

endmodule

// File: rtl/conv_mac_pipe.sv
// Pipelined signed MAC for convolution windows.
// It multiplies, accumulates over a first..last window, then rounds, shifts and saturates.
// A result is held in the output register until the consumer accepts it.
module conv_mac_pipe
    import conv_mac_pkg::*;
#(
    parameter int ID        = 1,
    parameter int A_W       = DEF_A_W,
    parameter int B_W       = DEF_B_W,
    parameter int NUM_STAGE = DEF_NUM_STAGE,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int SHIFT     = DEF_SHIFT,
    parameter int OUT_W     = DEF_OUT_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce,
    conv_mac_pipe_if.slave  bus
);
    // Reject configurations the datapath cannot represent.
    if (NUM_STAGE < 1) begin : g_bad_stage
        $error("conv_mac_pipe: NUM_STAGE must be at least 1");
    end
    if (ACC_W < A_W + B_W || ACC_W >= CALC_W) begin : g_bad_acc
        $error("conv_mac_pipe: ACC_W out of range");
    end
    if (SHIFT < 0 || SHIFT >= ACC_W) begin : g_bad_shift
        $error("conv_mac_pipe: SHIFT out of range");
    end
    if (OUT_W < 2 || OUT_W >= CALC_W) begin : g_bad_out
        $error("conv_mac_pipe: OUT_W out of range");
    end
    if (ID < 0) begin : g_bad_id
        $error("conv_mac_pipe: ID must be non-negative");
    end

    logic                    w_en;
    logic                    w_load;
    mac_tag_t                w_in_tag;
    mac_tag_t                w_pipe_tag;
    logic signed [ACC_W-1:0] w_pipe_prod;
    logic signed [ACC_W-1:0] w_acc_next;
    sat_res_t                w_sat;
    logic                    w_unused_bits;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [OUT_W-1:0] r_dout;
    logic                    r_out_valid;
    logic                    r_out_sat;

    // The whole datapath advances together.
    // It stops on clock enable, or while a result waits on the consumer.
    assign w_en        = ce && (!r_out_valid || bus.out_ready);
    assign bus.in_ready = w_en;

    // Build the tag for the incoming beat. Valid is set only if the beat is accepted.
    always_comb begin
        w_in_tag       = '0;
        w_in_tag.valid = bus.in_valid && w_en;
        w_in_tag.first = bus.in_first;
        w_in_tag.last  = bus.in_last;
    end

    conv_mac_mul_pipe #(
        .A_W       (A_W),
        .B_W       (B_W),
        .ACC_W     (ACC_W),
        .NUM_STAGE (NUM_STAGE)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .en     (w_en),
        .i_a    (bus.din0),
        .i_b    (bus.din1),
        .i_tag  (w_in_tag),
        .o_prod (w_pipe_prod),
        .o_tag  (w_pipe_tag)
    );

    // Next accumulator value and its requantised, saturated form.
    // A first beat restarts the sum; the ACC_W-bit add wraps.
    always_comb begin
        w_acc_next = w_pipe_tag.first ? w_pipe_prod : r_acc + w_pipe_prod;
        w_sat      = saturate(round_shift(CALC_W'(w_acc_next), SHIFT), OUT_W);
    end

    assign w_load        = w_en && w_pipe_tag.valid && w_pipe_tag.last;
    assign w_unused_bits = &{1'b0, w_sat.value[CALC_W-1:OUT_W]};

    // The accumulator moves only when a valid product reaches the end of the multiplier.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (w_en && w_pipe_tag.valid) begin
            r_acc <= w_acc_next;
        end
    end

    // Output register logic:
    // - A load takes priority and also keeps out_valid set when the old result is being consumed.
    // - Otherwise out_valid clears when the consumer accepts the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
            r_dout      <= '0;
        end else if (w_en) begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_sat   <= w_sat.sat;
                r_dout      <= w_sat.value[OUT_W-1:0];
            end else if (r_out_valid) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.dout      = r_dout;
    assign bus.out_sat   = r_out_sat;

endmodule
